mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction-fetch requester and a load/store
// requester. Ties alternate between them, and each wait for MemReady is bounded.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic              IValid,
    output logic [DATA_W-1:0] IRData,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic              DValid,
    output logic [DATA_W-1:0] DRData,
    output logic              Err,
    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemReady
);
    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IBUSY = 2'd1,
        S_DBUSY = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_d;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ivalid;
    logic              r_dvalid;
    logic              r_err;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_irdata;
    logic [DATA_W-1:0] r_drdata;
    logic              w_i_elig;
    logic              w_d_elig;
    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_done;
    logic              w_abort;

    // A requester is not eligible while its own completion pulse is showing.
    assign w_i_elig = IReq & ~r_ivalid;
    assign w_d_elig = DReq & ~r_dvalid;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_i     = 1'b0;
        w_gnt_d     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_d_elig && (!w_i_elig || !r_last_d)) begin
                    w_gnt_d     = 1'b1;
                    w_state_nxt = S_DBUSY;
                end else if (w_i_elig) begin
                    w_gnt_i     = 1'b1;
                    w_state_nxt = S_IBUSY;
                end
            end
            S_IBUSY, S_DBUSY: begin
                // A ready on the last allowed cycle still completes normally.
                if (MemReady) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant latching, wait counter, completion pulses and read data capture.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_last_d    <= 1'b0;
            r_cnt       <= '0;
            r_ivalid    <= 1'b0;
            r_dvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_irdata    <= '0;
            r_drdata    <= '0;
        end else begin
            r_ivalid <= 1'b0;
            r_dvalid <= 1'b0;
            r_err    <= 1'b0;
            if (w_gnt_i) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= IAddr;
                r_cnt      <= '0;
                r_last_d   <= 1'b0;
            end else if (w_gnt_d) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= DWe;
                r_mem_addr  <= DAddr;
                r_mem_wdata <= DWData;
                r_cnt       <= '0;
                r_last_d    <= 1'b1;
            end else if (w_done || w_abort) begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
                r_err    <= w_abort;
                if (r_state == S_IBUSY) begin
                    r_ivalid <= 1'b1;
                    if (w_done) r_irdata <= MemRData;
                end else begin
                    r_dvalid <= 1'b1;
                    if (w_done && !r_mem_we) r_drdata <= MemRData;
                end
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign IValid   = r_ivalid;
    assign IRData   = r_irdata;
    assign DValid   = r_dvalid;
    assign DRData   = r_drdata;
    assign Err      = r_err;
    assign MemEn    = r_mem_en;
    assign MemWe    = r_mem_we;
    assign MemAddr  = r_mem_addr;
    assign MemWData = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run, all outputs
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          Clk;
    logic          Rst;
    logic          IReq;
    logic [AW-1:0] IAddr;
    logic          IValid;
    logic [DW-1:0] IRData;
    logic          DReq;
    logic          DWe;
    logic [AW-1:0] DAddr;
    logic [DW-1:0] DWData;
    logic          DValid;
    logic [DW-1:0] DRData;
    logic          Err;
    logic          MemEn;
    logic          MemWe;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWData;
    logic [DW-1:0] MemRData;
    logic          MemReady;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .IReq(IReq), .IAddr(IAddr), .IValid(IValid), .IRData(IRData),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
        .DValid(DValid), .DRData(DRData), .Err(Err),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemReady(MemReady)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner 0 = none, 1 = fetch, 2 = load/store.
    // An access granted with latency L sees MemReady on busy cycle L (0-based);
    // if that never happens within TO busy cycles it is aborted with Err.
    int            m_owner;
    int            m_last;
    int            m_k;
    int            m_lat;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    logic          e_ivalid;
    logic          e_dvalid;
    logic          e_err;
    logic [DW-1:0] e_irdata;
    logic [DW-1:0] e_drdata;

    int            k_lat;
    bit            k_rdata_fix;
    logic [DW-1:0] k_rdata;
    int            obs[$];

    task automatic model_reset();
        m_owner  = 0;
        m_last   = 1;
        m_k      = 0;
        m_lat    = 0;
        m_addr   = '0;
        m_wdata  = '0;
        m_we     = 1'b0;
        e_ivalid = 1'b0;
        e_dvalid = 1'b0;
        e_err    = 1'b0;
        e_irdata = '0;
        e_drdata = '0;
    endtask

    task automatic model_update();
        bit ie, de, n_iv, n_dv, n_err;
        int g;
        if (Rst) begin
            model_reset();
            return;
        end
        ie    = IReq && !e_ivalid;
        de    = DReq && !e_dvalid;
        n_iv  = 1'b0;
        n_dv  = 1'b0;
        n_err = 1'b0;
        if (m_owner == 0) begin
            g = 0;
            if (ie && de) g = (m_last == 1) ? 2 : 1;
            else if (de)  g = 2;
            else if (ie)  g = 1;
            if (g != 0) begin
                m_owner = g;
                m_last  = g;
                m_k     = 0;
                m_addr  = (g == 1) ? IAddr : DAddr;
                m_we    = (g == 2) && DWe;
                m_wdata = DWData;
                m_lat   = (k_lat >= 0) ? k_lat : int'($urandom_range(0, TO + 1));
            end
        end else if (m_k == m_lat) begin
            if (m_owner == 1) begin
                n_iv     = 1'b1;
                e_irdata = MemRData;
            end else begin
                n_dv = 1'b1;
                if (!m_we) e_drdata = MemRData;
            end
            m_owner = 0;
        end else if (m_k + 1 == int'(TO)) begin
            if (m_owner == 1) n_iv = 1'b1;
            else              n_dv = 1'b1;
            n_err   = 1'b1;
            m_owner = 0;
        end else begin
            m_k++;
        end
        e_ivalid = n_iv;
        e_dvalid = n_dv;
        e_err    = n_err;
    endtask

    task automatic check_outputs();
        check("IValid", IValid, e_ivalid);
        check("DValid", DValid, e_dvalid);
        check("Err", Err, e_err);
        check("MemEn", MemEn, m_owner != 0);
        check("MemWe", MemWe, (m_owner == 2) && m_we);
        check("IRData", IRData, e_irdata);
        check("DRData", DRData, e_drdata);
        check("one_valid", IValid & DValid, 0);
        if (m_owner != 0) check("MemAddr", MemAddr, m_addr);
        if (m_owner == 2) check("MemWData", MemWData, m_wdata);
    endtask

    task automatic begin_cycle();
        @(posedge Clk);
        #1;
        check_outputs();
        if (IValid === 1'b1) obs.push_back(1);
        if (DValid === 1'b1) obs.push_back(2);
    endtask

    task automatic drive_mem();
        MemRData = k_rdata_fix ? k_rdata : DW'($urandom);
        if (m_owner != 0) MemReady = (m_k == m_lat);
        else              MemReady = 1'($urandom_range(0, 1));
    endtask

    task automatic end_cycle();
        drive_mem();
        model_update();
    endtask

    task automatic run_to_valid(input int who, input int budget,
                                output int cycles, output int en_cycles, output bit seen);
        cycles    = 0;
        en_cycles = 0;
        seen      = 1'b0;
        while (!seen && cycles < budget) begin
            begin_cycle();
            cycles++;
            if (MemEn === 1'b1) en_cycles++;
            if ((who == 1 && IValid === 1'b1) || (who == 2 && DValid === 1'b1)) begin
                seen = 1'b1;
                if (who == 1) IReq = 1'b0;
                else          DReq = 1'b0;
            end
            end_cycle();
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 4 * int'(TO) && (m_owner != 0 || e_ivalid || e_dvalid); c++) begin
            begin_cycle();
            IReq = 1'b0;
            DReq = 1'b0;
            end_cycle();
        end
        begin_cycle();
        end_cycle();
    endtask

    task automatic rand_inputs();
        IAddr  = AW'($urandom);
        DAddr  = AW'($urandom);
        DWData = DW'($urandom);
        DWe    = 1'($urandom_range(0, 1));
        if (!IReq || IValid) IReq = ($urandom_range(0, 99) < 60);
        if (!DReq || DValid) DReq = ($urandom_range(0, 99) < 60);
    endtask

    initial begin
        int cyc, en, first;
        bit seen;
        Rst = 1'b1; IReq = 1'b0; DReq = 1'b0; DWe = 1'b0;
        IAddr = '0; DAddr = '0; DWData = '0; MemRData = '0; MemReady = 1'b0;
        k_lat = -1; k_rdata_fix = 1'b0; k_rdata = '0;
        model_reset();

        // Reset values, then a single fetch with memory ready at once.
        begin_cycle(); end_cycle();
        begin_cycle();
        check("rst_MemAddr", MemAddr, 0);
        check("rst_MemWData", MemWData, 0);
        Rst = 1'b0;
        IReq = 1'b1; IAddr = 32'h40; k_lat = 0; k_rdata_fix = 1'b1; k_rdata = 32'h8C01_0004;
        end_cycle();
        begin_cycle();
        check("f_MemEn", MemEn, 1);
        check("f_MemAddr", MemAddr, 32'h40);
        end_cycle();
        begin_cycle();
        check("f_IValid", IValid, 1);
        check("f_IRData", IRData, 32'h8C01_0004);
        IReq = 1'b0;
        end_cycle();
        begin_cycle();
        check("f_MemEn_off", MemEn, 0);
        end_cycle();

        // Store held off by five cycles of MemReady low.
        k_rdata_fix = 1'b0; k_lat = 5;
        begin_cycle();
        DReq = 1'b1; DWe = 1'b1; DAddr = 32'h100; DWData = 32'hDEAD_BEEF;
        end_cycle();
        run_to_valid(2, 20, cyc, en, seen);
        check("st_seen", seen, 1);
        check("st_en_cycles", en, 6);
        check("st_DRData", DRData, 0);

        // Load that never sees MemReady: abort with Err after TO busy cycles.
        k_lat = TO + 5;
        begin_cycle();
        DReq = 1'b1; DWe = 1'b0; DAddr = AW'($urandom);
        end_cycle();
        run_to_valid(2, 4 * TO, cyc, en, seen);
        check("to_seen", seen, 1);
        check("to_en_cycles", en, TO);
        check("to_DRData", DRData, 0);
        k_lat = 0;
        begin_cycle();
        IReq = 1'b1; IAddr = AW'($urandom);
        end_cycle();
        run_to_valid(1, 10, cyc, en, seen);
        check("to_next_seen", seen, 1);
        check("to_next_latency", cyc, 2);

        // Both requesters continuously pending: grants alternate from D.
        drain();
        obs.delete();
        k_lat = 1;
        begin_cycle();
        IReq = 1'b1; DReq = 1'b1;
        end_cycle();
        for (int c = 0; c < 60 && obs.size() < 4; c++) begin
            begin_cycle();
            DWe = 1'($urandom_range(0, 1));
            DAddr = AW'($urandom); DWData = DW'($urandom); IAddr = AW'($urandom);
            end_cycle();
        end
        check("alt_count", obs.size() >= 4, 1);
        if (obs.size() >= 4)
            for (int i = 0; i < 4; i++)
                check($sformatf("alt_order_%0d", i), obs[i], (i % 2 == 0) ? 2 : 1);

        // Reset in the middle of a load: access dropped, next tie goes to D.
        drain();
        k_lat = TO + 5;
        begin_cycle();
        DReq = 1'b1; DWe = 1'b0; DAddr = AW'($urandom);
        end_cycle();
        begin_cycle();
        check("rm_busy", MemEn, 1);
        end_cycle();
        begin_cycle();
        Rst = 1'b1;
        #1;
        check("rm_MemEn", MemEn, 0);
        check("rm_DValid", DValid, 0);
        check("rm_Err", Err, 0);
        end_cycle();
        begin_cycle();
        Rst = 1'b0; IReq = 1'b1; DReq = 1'b1; k_lat = 0;
        obs.delete();
        end_cycle();
        for (int c = 0; c < 10 && obs.size() == 0; c++) begin
            begin_cycle();
            end_cycle();
        end
        first = (obs.size() > 0) ? obs[0] : 0;
        check("rm_first_grant", first, 2);

        // Randomized traffic with random memory latency, including timeouts.
        drain();
        k_lat = -1;
        for (int c = 0; c < 1500; c++) begin
            begin_cycle();
            rand_inputs();
            end_cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
